// File: rtl/tiny_soc_imem_loader.sv
// Program loader + instruction memory: deserialises nibbles into words after reset, then serves fetches.
// Optional debug echo port enabled by defining TINY_SOC_IMEM_ECHO_EN.
//
// state  | meaning
// S_LOAD | collecting nibbles from nib_in, writing one word every fourth edge
// S_RUN  | serving fetch_addr reads; left only by rst
module tiny_soc_imem_loader #(
  parameter int NUM_WORDS = 16,
  parameter int WORD_W    = 16,
  parameter int NIB_W     = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NIB_W-1:0]              nib_in,
  input  logic [$clog2(NUM_WORDS)-1:0]  fetch_addr,
  output logic [WORD_W-1:0]             fetch_data,
  output logic                          load_done
`ifdef TINY_SOC_IMEM_ECHO_EN
  ,
  output logic [NIB_W-1:0]              echo_out
`endif
);

  localparam int NIBS = WORD_W / NIB_W;
  localparam int CW   = (NIBS > 1) ? $clog2(NIBS) : 1;
  localparam int AW   = $clog2(NUM_WORDS);
  localparam logic [CW-1:0] LAST_NIB  = CW'(NIBS - 1);
  localparam logic [AW-1:0] LAST_WORD = AW'(NUM_WORDS - 1);

  typedef enum logic {S_LOAD = 1'b0, S_RUN = 1'b1} state_t;

  state_t                  state, next_state;
  logic [CW-1:0]           nib_cnt;
  logic [AW-1:0]           word_ptr;
  logic [WORD_W-NIB_W-1:0] sr;
  logic                    wr_en;
  logic [WORD_W-1:0]       mem [NUM_WORDS];

  always_ff @(posedge clk) begin
    if (rst) state <= S_LOAD;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    wr_en      = 1'b0;
    case (state)
      S_LOAD: begin
        if (nib_cnt == LAST_NIB) begin
          wr_en = 1'b1;
          if (word_ptr == LAST_WORD) next_state = S_RUN;
        end
      end
      S_RUN: next_state = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      nib_cnt    <= '0;
      word_ptr   <= '0;
      sr         <= '0;
      fetch_data <= '0;
    end else if (state == S_LOAD) begin
      fetch_data <= '0;
      if (wr_en) begin
        nib_cnt  <= '0;
        word_ptr <= word_ptr + 1'b1;
      end else begin
        sr[nib_cnt*NIB_W +: NIB_W] <= nib_in;
        nib_cnt                    <= nib_cnt + 1'b1;
      end
    end else begin
      fetch_data <= mem[fetch_addr];
    end
  end

  // Storage has no reset: contents survive rst until rewritten by a new load.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) mem[word_ptr] <= {nib_in, sr};
  end

  assign load_done = (state == S_RUN);

`ifdef TINY_SOC_IMEM_ECHO_EN
  logic [NIB_W-1:0] echo_q;

  always_ff @(posedge clk) begin
    if (rst)                  echo_q <= '0;
    else if (state == S_LOAD) echo_q <= nib_in;
  end

  assign echo_out = (state == S_RUN) ? fetch_data[NIB_W-1:0] : echo_q;
`endif

endmodule

// File: tb/tb_tiny_soc_imem_loader.sv
// Self-checking bench for tiny_soc_imem_loader: directed programs plus a random program,
// checked against a word-array model built from the nibble stream.
module tb_tiny_soc_imem_loader;

  typedef logic [15:0] prog_t [16];

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  nib_in = '0;
  logic [3:0]  fetch_addr = '0;
  logic [15:0] fetch_data;
  logic        load_done;
`ifdef TINY_SOC_IMEM_ECHO_EN
  logic [3:0]  echo_out;
`endif

  int errors = 0;
  int checks = 0;
  logic [15:0] model_mem [16];

  tiny_soc_imem_loader dut (
    .clk        (clk),
    .rst        (rst),
    .nib_in     (nib_in),
    .fetch_addr (fetch_addr),
    .fetch_data (fetch_data),
    .load_done  (load_done)
`ifdef TINY_SOC_IMEM_ECHO_EN
    ,
    .echo_out   (echo_out)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled on the following falling edge.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Streams nwords words LSB nibble first; the model learns each word once its 4th nibble lands.
  task automatic stream(input prog_t p, input int nwords);
    logic [15:0] w;
    int k;
    fetch_addr = 4'd0;
    for (k = 1; k <= nwords * 4; k++) begin
      w = p[(k - 1) / 4];
      nib_in = 4'((w >> (4 * ((k - 1) % 4))) & 16'hF);
      @(posedge clk);
      @(negedge clk);
      if ((k - 1) % 4 == 3) model_mem[(k - 1) / 4] = w;
      check($sformatf("load_done_e%0d", k), {31'b0, load_done},
            {31'b0, (nwords == 16 && k == 64)});
      check($sformatf("load_rd_zero_e%0d", k), {16'b0, fetch_data}, 32'h0);
`ifdef TINY_SOC_IMEM_ECHO_EN
      if (k < 64)
        check($sformatf("echo_e%0d", k), {28'b0, echo_out}, {28'b0, nib_in});
`endif
    end
    nib_in = 4'd0;
  endtask

  task automatic fetch(input logic [3:0] a);
    fetch_addr = a;
    @(posedge clk);
    @(negedge clk);
    check($sformatf("fetch_a%0d", a), {16'b0, fetch_data}, {16'b0, model_mem[a]});
`ifdef TINY_SOC_IMEM_ECHO_EN
    check($sformatf("echo_run_a%0d", a), {28'b0, echo_out}, {28'b0, model_mem[a][3:0]});
`endif
  endtask

  initial begin
    prog_t p;

    // Reset values
    @(posedge clk);
    @(negedge clk);
    check("rst_load_done", {31'b0, load_done}, 32'h0);
    check("rst_fetch_data", {16'b0, fetch_data}, 32'h0);
`ifdef TINY_SOC_IMEM_ECHO_EN
    check("rst_echo", {28'b0, echo_out}, 32'h0);
`endif
    rst = 1'b0;

    // Program load from the example stream
    for (int i = 0; i < 16; i++) p[i] = 16'h0000;
    p[0] = 16'h7804; p[1] = 16'h7401; p[2] = 16'h1AE0; p[3] = 16'h8000;
    stream(p, 16);
    for (int i = 0; i < 16; i++) fetch(4'(i));
    check("golden_w0", {16'b0, model_mem[0]}, 32'h7804);
    check("golden_w3", {16'b0, model_mem[3]}, 32'h8000);

    // Back-to-back fetches with one-cycle latency
    fetch(4'd3);
    fetch(4'd0);
    fetch(4'd2);

    // Reset mid-load, then a full reload of 0xAAAA
    do_reset();
    p[0] = 16'h1111; p[1] = 16'h2222;
    stream(p, 2);
    do_reset();
    for (int i = 0; i < 16; i++) p[i] = 16'hAAAA;
    stream(p, 16);
    for (int i = 0; i < 16; i++) fetch(4'(i));

    // Reset during RUN
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("run_rst_load_done", {31'b0, load_done}, 32'h0);
    check("run_rst_fetch_data", {16'b0, fetch_data}, 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) p[i] = 16'h0000;
    p[5] = 16'h1234;
    stream(p, 16);
    fetch(4'd5);
    fetch(4'd4);

    // Random program, random fetch order
    do_reset();
    for (int i = 0; i < 16; i++) p[i] = 16'($urandom);
    stream(p, 16);
    for (int i = 0; i < 40; i++) fetch(4'($urandom_range(0, 15)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tiny_soc_imem_loader.md
# tiny_soc_imem_loader

Program loader and instruction memory for the tiny SoC core. After reset it deserialises 64 nibbles from the 4-bit input pins into sixteen 16-bit instruction words, then switches to run mode and serves the core's instruction fetches from the same storage. It sits between the chip input pins (nibble bus) and the core's fetch stage. It holds the core idle via `load_done` until the program is complete.

## Interface

Parameters:
- `NUM_WORDS`, 16: instruction words stored. Power of two.
- `WORD_W`, 16: instruction width. Must equal 4 × nibbles per word.
- `NIB_W`, 4: width of the serial input bus.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous reset, active-high.
- `nib_in` in 4: program nibble, sampled every rising edge while in LOAD.
- `fetch_addr` in 4: core instruction address. Used only in RUN.
- `fetch_data` out 16: registered instruction read data.
- `load_done` out 1: high in RUN. The core must not fetch while it is low.
- `echo_out` out 4: loader debug echo. Present only with `TINY_SOC_IMEM_ECHO_EN`.

## Operation

- Two states:
  - LOAD: the reset state.
  - RUN: entered after the 64th nibble. RUN is left only by `rst`.
- LOAD datapath: `nib_cnt` (2 bit), `word_ptr` (4 bit) and a 12-bit shift register `sr`.
- Nibble order is least-significant first: nibble 0 = bits [3:0], nibble 3 = bits [15:12].
- LOAD behaviour per edge:
  - `nib_cnt` < 3: `sr` captures the nibble at its position, then `nib_cnt` increments.
  - `nib_cnt` == 3: `mem[word_ptr]` is written with `{nib_in, sr}`, `nib_cnt` wraps to 0, and `word_ptr` increments.
  - When the write is to `word_ptr` == 15, the next state is RUN.
- Example: nibble stream 4,0,8,7 writes 0x7804. Stream 0,0,0,8 writes 0x8000.
- RUN: each edge, `fetch_data` ← `mem[fetch_addr]`. `nib_in` is ignored and no writes occur.
- LOAD reads: `fetch_data` ← 0 every edge.
- Reset:
  - Clears the state to LOAD and sets `nib_cnt`, `word_ptr`, `sr`, `fetch_data` and `echo_out` to 0.
  - Memory contents are not cleared.
  - Reset mid-load restarts loading at word 0, nibble 0. Words not yet rewritten keep stale contents.
  - Reset during RUN returns to LOAD and forces `load_done` low on the next edge.
- Reads and writes never coincide: their states are exclusive.

## Timing

- Edge k is the k-th rising edge with `rst` low. The first sampled nibble is taken at edge 1.
- Nibble at edge k goes to word ⌊(k−1)/4⌋, nibble (k−1) mod 4.
- Word writes happen at edges 4, 8, …, 64.
- `load_done` rises after edge 64 (registered state) and is valid from cycle 65.
- Fetch latency is 1 cycle: `fetch_addr` sampled at edge n gives `fetch_data` valid after edge n.
  - The first valid fetch samples at edge 65; its data is visible after edge 65.
- Output reset values: `fetch_data` = 0x0000, `load_done` = 0, `echo_out` = 0.
- No backpressure. The host must present one nibble per cycle, continuously, from edge 1 to edge 64.

## Configuration

- `TINY_SOC_IMEM_ECHO_EN` defined:
  - In LOAD, `echo_out` is a registered copy of the previous cycle's `nib_in`, so the host can verify the stream one cycle late.
  - In RUN, `echo_out` = `fetch_data[3:0]`.
- Not defined: the `echo_out` port and its register are absent. All other behaviour is identical.

## Test plan

- **Program load.** After reset, stream 4,0,8,7 / 1,0,4,7 / 0,E,A,1 / 0,0,0,8 then 48 zero nibbles. Required:
  - `load_done` is 0 through edge 64 and 1 from cycle 65.
  - Fetching addresses 0..3 returns 0x7804, 0x7401, 0x1AE0, 0x8000.
  - Fetching address 4..15 returns 0x0000.
- **Fetch latency.** In RUN, drive `fetch_addr` 3, 0, 2 on consecutive edges. `fetch_data` must read 0x8000, 0x7804, 0x1AE0, each one cycle after its address.
- **LOAD read suppression.** During LOAD, drive `fetch_addr` = 0 with a previously loaded program. `fetch_data` must stay 0x0000 until after edge 65.
- **Reset mid-load.** Load words 0..1 with 0x1111 and 0x2222, assert `rst` for one cycle, then stream 0xAAAA for all 16 words. Required:
  - All 16 words read 0xAAAA.
  - `load_done` rises exactly 64 edges after the reset is released.
- **Reset during RUN.** Assert `rst` in RUN. Required:
  - `load_done` = 0 and `fetch_data` = 0 after the edge.
  - Without a reload, memory still holds the old contents: issue a new 64-nibble load of all zeros except word 5 = 0x1234, then read word 5 = 0x1234.
- **Echo (`TINY_SOC_IMEM_ECHO_EN`).** Stream nibbles 4,0,8,7. `echo_out` must equal 4, 0, 8, 7, each one cycle after its input.
